// File: rtl/cpu_pkg.sv
// Shared types for the data-memory arbiter: FSM states and read-return owner tags.
package cpu_pkg;
  localparam int MEM_RD_LAT = 1;

  typedef enum logic {S_CPU, S_ACC} arb_state_t;
  typedef enum logic [1:0] {NONE, CPU, ACC} owner_t;
endpackage

// File: rtl/dmem_burst_ctr.sv
// Accelerator burst beat counter: latches base/length on load, steps one beat per
// cycle, and produces the wrapped beat address plus a last-beat flag.
module dmem_burst_ctr #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  last_idx;
  logic [LEN_W-1:0]  load_idx;

  // Zero-length requests still run one beat; oversize requests are clamped.
  always_comb begin
    load_idx = '0;
    if (len > MAX_LEN)    load_idx = MAX_LEN - LEN_W'(1);
    else if (len != '0)   load_idx = len - LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      beat_cnt <= '0;
      last_idx <= '0;
    end else if (load) begin
      base_q   <= base;
      beat_cnt <= '0;
      last_idx <= load_idx;
    end else if (step) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  assign addr = base_q + ADDR_W'(beat_cnt);
  assign last = (beat_cnt == last_idx);
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU MEM stage owns the port by default; the NN accelerator
// gets multi-beat bursts when the CPU is idle or after STARVE_LIMIT denied cycles.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_BURST    = 8,
  parameter int LEN_W        = $clog2(MAX_BURST + 1),
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_wready,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state, state_nx;
  owner_t            rd_owner, owner_nx;
  logic [SW-1:0]     starve_cnt;
  logic              acc_we_q, done_q;
  logic              grant, cpu_any, burst_last;
  logic              en_c, we_c, stall_c, wready_c;
  logic [ADDR_W-1:0] burst_addr;

  assign cpu_any = cpu_rd | cpu_wr;

  dmem_burst_ctr #(
    .ADDR_W   (ADDR_W),
    .MAX_BURST(MAX_BURST),
    .LEN_W    (LEN_W)
  ) u_burst_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (grant),
    .step (state == S_ACC),
    .base (acc_addr),
    .len  (acc_len),
    .addr (burst_addr),
    .last (burst_last)
  );

  always_comb begin
    state_nx  = state;
    owner_nx  = NONE;
    grant     = 1'b0;
    en_c      = 1'b0;
    we_c      = 1'b0;
    stall_c   = 1'b0;
    wready_c  = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (state)
      S_CPU: begin
        en_c  = cpu_any;
        we_c  = cpu_wr;
        grant = acc_req & (~cpu_any | (starve_cnt == STARVE_MAX));
        if (grant) state_nx = S_ACC;
        if (cpu_rd && !cpu_wr) owner_nx = CPU;
      end
      S_ACC: begin
        en_c      = 1'b1;
        we_c      = acc_we_q;
        wready_c  = acc_we_q;
        stall_c   = cpu_any;
        mem_addr  = burst_addr;
        mem_wdata = acc_wdata;
        owner_nx  = acc_we_q ? NONE : ACC;
        if (burst_last) state_nx = S_CPU;
      end
      default: state_nx = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CPU;
      rd_owner   <= NONE;
      starve_cnt <= '0;
      acc_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_owner <= owner_nx;
      done_q   <= (state == S_ACC) && burst_last;
      if (grant) begin
        starve_cnt <= '0;
        acc_we_q   <= acc_we;
      end else if (state == S_CPU && acc_req && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // Strobes are gated so nothing reaches the memory while reset is held.
  assign mem_en     = rst_n & en_c;
  assign mem_we     = rst_n & we_c;
  assign cpu_stall  = rst_n & stall_c;
  assign acc_gnt    = rst_n & grant;
  assign acc_wready = rst_n & wready_c;
  assign acc_done   = done_q;
  assign acc_rvalid = (rd_owner == ACC);
  assign acc_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;
endmodule
